// File: rtl/spi_cmd_arbiter.sv
// SPI master for the GPIO expander: round-robin arbiter over two
// requesters, each pair sent as a cmd frame then a data frame.
`timescale 1ns/1ps
module spi_cmd_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_cmd,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_cmd,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD_FRAME,
    GAP1,
    DATA_FRAME,
    GAP2,
    DONE
  } state_t;

  state_t        state;
  logic          last_grant;
  logic          cur_id;
  logic          setup;
  logic          hi;
  logic [7:0]    data_q;
  logic [7:0]    tx;
  logic [7:0]    rx;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    grant;
  logic          idle;
  logic          div_end;
  logic [7:0]    sel_cmd;

  assign idle    = (state == IDLE);
  assign div_end = (div_cnt == DIV_MAX);
  assign busy    = ~idle;
  assign sel_cmd = grant[1] ? req1_cmd : req0_cmd;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req0_valid & req1_valid):
        grant = last_grant ? 2'b01 : 2'b10;
      (req0_valid & ~req1_valid):
        grant = 2'b01;
      (~req0_valid & req1_valid):
        grant = 2'b10;
      default:
        grant = 2'b00;
    endcase
  end

  // Gated by rst so no grant is visible while reset is held.
  assign req0_ready = rst & idle & grant[0];
  assign req1_ready = rst & idle & grant[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      setup      <= 1'b0;
      hi         <= 1'b0;
      data_q     <= '0;
      tx         <= '0;
      rx         <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      ss         <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            cur_id     <= grant[1];
            last_grant <= grant[1];
            data_q     <= grant[1] ? req1_data : req0_data;
            tx         <= sel_cmd;
            mosi       <= sel_cmd[7];
            ss         <= 1'b1;
            sclk       <= 1'b0;
            setup      <= 1'b1;
            hi         <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            rx         <= '0;
            state      <= CMD_FRAME;
          end
        end
        CMD_FRAME, DATA_FRAME: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            unique case (1'b1)
              setup: begin
                setup <= 1'b0;
                hi    <= 1'b1;
                sclk  <= 1'b1;
              end
              hi: begin
                hi   <= 1'b0;
                sclk <= 1'b0;
                rx   <= {rx[6:0], miso};
                if (bit_cnt != 3'd7) begin
                  mosi <= tx[6];
                  tx   <= {tx[6:0], 1'b0};
                end
              end
              default: begin
                if (bit_cnt == 3'd7) begin
                  ss      <= 1'b0;
                  gap_cnt <= '0;
                  state   <= (state == CMD_FRAME)
                             ? GAP1 : GAP2;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  hi      <= 1'b1;
                  sclk    <= 1'b1;
                end
              end
            endcase
          end
        end
        GAP1: begin
          if (gap_cnt == GAP_MAX) begin
            tx      <= data_q;
            mosi    <= data_q[7];
            ss      <= 1'b1;
            sclk    <= 1'b0;
            setup   <= 1'b1;
            hi      <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            rx      <= '0;
            state   <= DATA_FRAME;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        GAP2: begin
          if (gap_cnt == GAP_MAX) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_data  <= rx;
            state     <= DONE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
